stream_mux_rr: RTL
==================

# stream_mux_rr

Parametrised N-input streaming multiplexer with valid/ready handshakes, a registered output stage and two selection modes: externally selected (the classic select-driven mux) or round-robin arbitration across requesting inputs. It sits between multiple producers and one consumer, for example merging datapath lanes into a single bus. It adds back-pressure, fairness and source tagging that a plain combinational select mux does not provide.

## Interface
- `N_IN`, default 4: number of input channels; must be at least 2.
- `DATA_W`, default 4: payload width in bits.
- `SEL_W`, default `$clog2(N_IN)`: width of the select and source-tag fields; derived, not overridden.
- `clk`  in  1: single clock; all state is updated on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mode`  in  1: 0 = fixed select via `sel`; 1 = round-robin.
- `sel`  in  SEL_W: input index used when `mode`=0. Values of `N_IN` or above select nothing.
- `in_valid`  in  N_IN: per-channel valid.
- `in_data`  in  N_IN*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- `in_ready`  out  N_IN: per-channel ready; one-hot or zero.
- `out_valid`  out  1: output register holds a beat.
- `out_data`  out  DATA_W: registered payload.
- `out_src`  out  SEL_W: index of the channel that supplied `out_data`.
- `out_ready`  in  1: consumer accepts the beat.

## Operation
- The output stage is a single register. It can load a beat when `load_ok` = `!out_valid || out_ready`.
- `grant` is the candidate channel index, computed combinationally each cycle:
  - `mode`=0: `grant` = `sel` if `sel` < N_IN and `in_valid[sel]`; otherwise there is no grant.
  - `mode`=1: search upward from `rr_ptr+1`, wrapping modulo N_IN. `grant` is the first index i with `in_valid[i]`; if no input is valid there is no grant.
- `in_ready[i]` = `load_ok && grant_valid && grant==i`. All other channels see `in_ready`=0.
- On an input transfer (`in_valid[i] && in_ready[i]`): `out_data` ← channel i data, `out_src` ← i, `out_valid` ← 1.
- On an output transfer with no input transfer in the same cycle: `out_valid` ← 0. `out_data` and `out_src` hold their values.
- `rr_ptr` ← i only on an input transfer in `mode`=1. It is unchanged in `mode`=0, so switching modes resumes fairness where it left off.
- A change of `mode` or `sel` takes effect on the grant in the same cycle. It never alters a beat already held in the output register.
- Inputs must follow the stream rule: once `in_valid` is raised it is held, with data stable, until accepted. The mux does not check this.

## Timing
- Reset values (asynchronous on `rst_n` low, applied immediately): `out_valid`=0, `out_data`=0, `out_src`=0, `rr_ptr`=N_IN-1, so channel 0 has first priority. `in_ready` is 0 while `out_valid`=0 and no input is valid.
- Latency is 1 cycle from an input transfer to `out_valid`.
- Throughput is 1 beat per cycle when `out_ready` is held at 1. A simultaneous output and input transfer replaces the register contents with no bubble.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode` and `sel`. No input valid depends on a ready.
- Back-pressure: when `out_valid`=1 and `out_ready`=0, every `in_ready` is 0 and the register holds.
- Round-robin fairness: with all N_IN inputs continuously valid and no stall, every channel is granted exactly once in each N_IN consecutive transfers.
- Reset mid-transfer: any held beat is discarded, and arbitration restarts at channel 0.

## Test plan
- Reset with `in_valid`=4'b1111: while `rst_n`=0, `out_valid`=0 and `in_ready`=0. In the first cycle after release, channel 0 is granted, and the next cycle shows `out_src`=0.
- `mode`=0, `sel`=2, `in_valid`=4'b0100, `in_data[2]`=4'hA -> one cycle later `out_valid`=1, `out_data`=4'hA, `out_src`=2; `in_ready`=4'b0000 on channels other than 2.
- `mode`=0, `sel`=1, `in_valid`=4'b1101 -> no grant, `in_ready`=0 and `out_valid` stays 0.
- `mode`=1, all four valid with data 4'h1, 4'h2, 4'h3, 4'h4, `out_ready`=1 -> the output sequence is `out_src` 0, 1, 2, 3, 0, … with matching data and no bubbles.
- `mode`=1 with `out_ready` held at 0 for 3 cycles after the first beat -> `out_data` is stable, `in_ready`=0 and `rr_ptr` is frozen; on release, the next granted source is 1.
- `mode`=1 with `in_valid`=4'b1001 and `rr_ptr`=3 -> grant 0, then grant 3, alternating; channels 1 and 2 never see `in_ready`=1.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream multiplexer with a single registered output stage.
// Selection is either a fixed external index or round-robin across requesting inputs.
module stream_mux_rr #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  output logic [N_IN-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_src,
  input  logic                     out_ready
);

  localparam int CW = SEL_W + 1;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]     out_src_q, out_src_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [DATA_W-1:0]    ch_data [N_IN];
  logic [SEL_W-1:0]     grant;
  logic                 grant_valid;
  logic [CW-1:0]        cand;
  logic                 load_ok;
  logic                 in_xfer;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
    assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    if (!mode) begin
      if (({1'b0, sel} < CW'(N_IN)) && in_valid[sel]) begin
        grant       = sel;
        grant_valid = 1'b1;
      end
    end else begin
      // Walk upward from the channel after the last winner, wrapping at N_IN.
      for (int k = 1; k <= N_IN; k++) begin
        cand = {1'b0, rr_ptr_q} + CW'(k);
        if (cand >= CW'(N_IN)) begin
          cand = cand - CW'(N_IN);
        end
        if (!grant_valid && in_valid[cand[SEL_W-1:0]]) begin
          grant       = cand[SEL_W-1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Reset also gates acceptance so no producer sees a handshake while held in reset.
  assign load_ok  = rst_n && (!out_valid_q || out_ready);
  assign in_xfer  = load_ok && grant_valid;
  assign in_ready = in_xfer ? (N_IN'(1) << grant) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant];
      out_src_d   = grant;
      if (mode) begin
        rr_ptr_d = grant;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= SEL_W'(N_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
